// File: rtl/sliding_window_stats.sv
// Sliding-window sum and sum-of-squares over the last NA accepted samples.
//
// Ports:
//   CLK          rising-edge clock
//   RESET_N      synchronous active-low reset; also captures N into NA
//   SAMPLE       accepts TN on a rising edge when high
//   TN           unsigned sample value
//   N            requested window length; only captured at reset or CLEAR
//                (0 or values above MAX_DEPTH select MAX_DEPTH)
//   CLEAR        synchronous flush of the window and recapture of N; wins over SAMPLE
//   TSUM         sum of the samples currently in the window (registered)
//   TSUM_SQUARE  sum of squares of the samples currently in the window (registered)
//   COUNT        number of samples currently in the window (registered)
//   FULL         high when COUNT equals the active window length
module sliding_window_stats #(
    parameter int DATA_W    = 12,
    parameter int MAX_DEPTH = 14,
    localparam int CW       = $clog2(MAX_DEPTH + 1),
    localparam int SUM_W    = DATA_W + CW,
    localparam int SQ_W     = 2 * DATA_W + CW
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              SAMPLE,
    input  logic [DATA_W-1:0] TN,
    input  logic [CW-1:0]     N,
    input  logic              CLEAR,
    output logic [SUM_W-1:0]  TSUM,
    output logic [SQ_W-1:0]   TSUM_SQUARE,
    output logic [CW-1:0]     COUNT,
    output logic              FULL
);

    localparam int            PW      = 2 * DATA_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(MAX_DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILL,
        ST_FULL
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] win_q [MAX_DEPTH];
    logic [DATA_W-1:0] win_d [MAX_DEPTH];
    logic [PW-1:0]     sq_q  [MAX_DEPTH];
    logic [PW-1:0]     sq_d  [MAX_DEPTH];
    logic [SUM_W-1:0]  tsum_q, tsum_d;
    logic [SQ_W-1:0]   tsq_q, tsq_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     na_q, na_d;

    logic [CW-1:0]     n_eff;
    logic [PW-1:0]     tn_sq;
    logic [DATA_W-1:0] old_s;
    logic [PW-1:0]     old_sq;

    always_comb n_eff = (N == '0 || N > DEPTH_C) ? DEPTH_C : N;

    always_comb tn_sq = PW'(TN) * PW'(TN);

    // Oldest sample still inside the active window (entry NA-1, pre-shift).
    always_comb begin
        old_s  = '0;
        old_sq = '0;
        for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
            if (CW'(i) == na_q - CW'(1)) begin
                old_s  = win_q[i];
                old_sq = sq_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        sq_d    = sq_q;
        tsum_d  = tsum_q;
        tsq_d   = tsq_q;
        count_d = count_q;
        na_d    = na_q;

        if (CLEAR) begin
            for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
                win_d[i] = '0;
                sq_d[i]  = '0;
            end
            tsum_d  = '0;
            tsq_d   = '0;
            count_d = '0;
            na_d    = n_eff;
            state_d = ST_EMPTY;
        end else if (SAMPLE) begin
            win_d[0] = TN;
            sq_d[0]  = tn_sq;
            for (int unsigned i = 1; i < MAX_DEPTH; i++) begin
                win_d[i] = win_q[i-1];
                sq_d[i]  = sq_q[i-1];
            end

            if (state_q == ST_FULL) begin
                // Add-new/subtract-oldest; the transient sum of NA+1 samples
                // still fits because 2^CW > MAX_DEPTH.
                tsum_d = tsum_q + SUM_W'(TN) - SUM_W'(old_s);
                tsq_d  = tsq_q + SQ_W'(tn_sq) - SQ_W'(old_sq);
            end else begin
                tsum_d  = tsum_q + SUM_W'(TN);
                tsq_d   = tsq_q + SQ_W'(tn_sq);
                count_d = count_q + CW'(1);
                state_d = (count_q + CW'(1) == na_q) ? ST_FULL : ST_FILL;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
                win_q[i] <= '0;
                sq_q[i]  <= '0;
            end
            tsum_q  <= '0;
            tsq_q   <= '0;
            count_q <= '0;
            na_q    <= n_eff;
            state_q <= ST_EMPTY;
        end else begin
            win_q   <= win_d;
            sq_q    <= sq_d;
            tsum_q  <= tsum_d;
            tsq_q   <= tsq_d;
            count_q <= count_d;
            na_q    <= na_d;
            state_q <= state_d;
        end
    end

    assign TSUM        = tsum_q;
    assign TSUM_SQUARE = tsq_q;
    assign COUNT       = count_q;
    assign FULL        = (state_q == ST_FULL);

endmodule

// File: tb/tb_sliding_window_stats.sv
// Self-checking bench for sliding_window_stats: directed scenarios with fixed
// expected values plus a randomized run against a queue-based window model.
module tb_sliding_window_stats;

    localparam int DATA_W    = 12;
    localparam int MAX_DEPTH = 14;
    localparam int CW        = 4;
    localparam int SUM_W     = 16;
    localparam int SQ_W      = 28;

    logic              CLK = 1'b0;
    logic              RESET_N;
    logic              SAMPLE;
    logic [DATA_W-1:0] TN;
    logic [CW-1:0]     N;
    logic              CLEAR;
    logic [SUM_W-1:0]  TSUM;
    logic [SQ_W-1:0]   TSUM_SQUARE;
    logic [CW-1:0]     COUNT;
    logic              FULL;

    int total = 0;
    int bad   = 0;

    // Reference window: newest sample at the front, at most m_na entries.
    int m_na = MAX_DEPTH;
    int m_q[$];

    always #5 CLK = ~CLK;

    sliding_window_stats #(
        .DATA_W   (DATA_W),
        .MAX_DEPTH(MAX_DEPTH)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .SAMPLE     (SAMPLE),
        .TN         (TN),
        .N          (N),
        .CLEAR      (CLEAR),
        .TSUM       (TSUM),
        .TSUM_SQUARE(TSUM_SQUARE),
        .COUNT      (COUNT),
        .FULL       (FULL)
    );

    function automatic int eff_n(input int n);
        return (n == 0 || n > MAX_DEPTH) ? MAX_DEPTH : n;
    endfunction

    function automatic longint m_sum();
        longint s = 0;
        foreach (m_q[i]) s += m_q[i];
        return s;
    endfunction

    function automatic longint m_sq();
        longint s = 0;
        foreach (m_q[i]) s += longint'(m_q[i]) * m_q[i];
        return s;
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle #1.
    task automatic tick(input logic rst_n, input logic smp, input logic clr,
                        input int tn, input int n);
        int nn;
        int tv;
        RESET_N = rst_n;
        SAMPLE  = smp;
        CLEAR   = clr;
        TN      = tn[DATA_W-1:0];
        N       = n[CW-1:0];
        nn      = int'(N);
        tv      = int'(TN);
        @(posedge CLK);
        if (!rst_n || clr) begin
            m_q.delete();
            m_na = eff_n(nn);
        end else if (smp) begin
            m_q.push_front(tv);
            if (m_q.size() > m_na) void'(m_q.pop_back());
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1, 1'b1, 123, 4);
        total++; if (TSUM !== 0) begin bad++; $display("FAIL reset_tsum: got %0d want 0", TSUM); end
        total++; if (TSUM_SQUARE !== 0) begin bad++; $display("FAIL reset_tsq: got %0d want 0", TSUM_SQUARE); end
        total++; if (COUNT !== 0) begin bad++; $display("FAIL reset_count: got %0d want 0", COUNT); end
        total++; if (FULL !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", FULL); end
    endtask

    task automatic test_basic();
        tick(1'b0, 1'b0, 1'b0, 0, 4);
        for (int v = 1; v <= 4; v++) tick(1'b1, 1'b1, 1'b0, v, 4);
        total++; if (TSUM !== 10) begin bad++; $display("FAIL basic_tsum: got %0d want 10", TSUM); end
        total++; if (TSUM_SQUARE !== 30) begin bad++; $display("FAIL basic_tsq: got %0d want 30", TSUM_SQUARE); end
        total++; if (COUNT !== 4) begin bad++; $display("FAIL basic_count: got %0d want 4", COUNT); end
        total++; if (FULL !== 1'b1) begin bad++; $display("FAIL basic_full: got %b want 1", FULL); end
        tick(1'b1, 1'b1, 1'b0, 5, 4);
        total++; if (TSUM !== 14) begin bad++; $display("FAIL slide_tsum: got %0d want 14", TSUM); end
        total++; if (TSUM_SQUARE !== 54) begin bad++; $display("FAIL slide_tsq: got %0d want 54", TSUM_SQUARE); end
        total++; if (COUNT !== 4) begin bad++; $display("FAIL slide_count: got %0d want 4", COUNT); end
    endtask

    task automatic test_max();
        longint want_sq;
        tick(1'b0, 1'b0, 1'b0, 0, 14);
        for (int k = 0; k < 14; k++) tick(1'b1, 1'b1, 1'b0, 4095, 14);
        total++; if (TSUM !== 57330) begin bad++; $display("FAIL max_tsum: got %0d want 57330", TSUM); end
        total++; if (TSUM_SQUARE !== 234766350) begin bad++; $display("FAIL max_tsq: got %0d want 234766350", TSUM_SQUARE); end
        total++; if (FULL !== 1'b1) begin bad++; $display("FAIL max_full: got %b want 1", FULL); end
        tick(1'b1, 1'b1, 1'b0, 0, 14);
        want_sq = 64'd13 * 4095 * 4095;
        total++; if (TSUM !== 53235) begin bad++; $display("FAIL max_drop_tsum: got %0d want 53235", TSUM); end
        total++; if (TSUM_SQUARE !== want_sq) begin bad++; $display("FAIL max_drop_tsq: got %0d want %0d", TSUM_SQUARE, want_sq); end
    endtask

    task automatic test_hold();
        tick(1'b0, 1'b0, 1'b0, 0, 3);
        tick(1'b1, 1'b1, 1'b0, 7, 3);
        tick(1'b1, 1'b1, 1'b0, 9, 3);
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'b0, 1'b0, int'($urandom_range(4095)), 5);
            total++; if (TSUM !== 16 || TSUM_SQUARE !== 130 || COUNT !== 2)
                begin bad++; $display("FAIL hold_cycle%0d: got %0d/%0d/%0d want 16/130/2", k, TSUM, TSUM_SQUARE, COUNT); end
        end
        tick(1'b1, 1'b1, 1'b0, 1, 5);
        tick(1'b1, 1'b1, 1'b0, 2, 5);
        total++; if (COUNT !== 3) begin bad++; $display("FAIL hold_na_count: got %0d want 3", COUNT); end
        total++; if (TSUM !== 12) begin bad++; $display("FAIL hold_na_tsum: got %0d want 12", TSUM); end
        total++; if (TSUM_SQUARE !== 86) begin bad++; $display("FAIL hold_na_tsq: got %0d want 86", TSUM_SQUARE); end
        total++; if (FULL !== 1'b1) begin bad++; $display("FAIL hold_na_full: got %b want 1", FULL); end
    endtask

    task automatic test_clear();
        tick(1'b0, 1'b0, 1'b0, 0, 4);
        for (int v = 1; v <= 4; v++) tick(1'b1, 1'b1, 1'b0, 10 * v, 4);
        tick(1'b1, 1'b1, 1'b1, 100, 2);
        total++; if (TSUM !== 0 || TSUM_SQUARE !== 0) begin bad++; $display("FAIL clear_sums: got %0d/%0d want 0/0", TSUM, TSUM_SQUARE); end
        total++; if (COUNT !== 0 || FULL !== 1'b0) begin bad++; $display("FAIL clear_count: got %0d/%b want 0/0", COUNT, FULL); end
        for (int v = 3; v <= 5; v++) tick(1'b1, 1'b1, 1'b0, v, 7);
        total++; if (TSUM !== 9) begin bad++; $display("FAIL clear_after_tsum: got %0d want 9", TSUM); end
        total++; if (TSUM_SQUARE !== 41) begin bad++; $display("FAIL clear_after_tsq: got %0d want 41", TSUM_SQUARE); end
        total++; if (COUNT !== 2 || FULL !== 1'b1) begin bad++; $display("FAIL clear_after_count: got %0d/%b want 2/1", COUNT, FULL); end
    endtask

    task automatic test_n_limits();
        tick(1'b0, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 15; k++) tick(1'b1, 1'b1, 1'b0, 1, 0);
        total++; if (COUNT !== 14) begin bad++; $display("FAIL nzero_count: got %0d want 14", COUNT); end
        total++; if (TSUM !== 14) begin bad++; $display("FAIL nzero_tsum: got %0d want 14", TSUM); end
        total++; if (FULL !== 1'b1) begin bad++; $display("FAIL nzero_full: got %b want 1", FULL); end
        tick(1'b0, 1'b0, 1'b0, 0, 15);
        for (int k = 0; k < 13; k++) tick(1'b1, 1'b1, 1'b0, 2, 15);
        total++; if (COUNT !== 13 || FULL !== 1'b0) begin bad++; $display("FAIL nbig_13: got %0d/%b want 13/0", COUNT, FULL); end
        tick(1'b1, 1'b1, 1'b0, 2, 15);
        total++; if (COUNT !== 14 || FULL !== 1'b1 || TSUM !== 28) begin bad++; $display("FAIL nbig_14: got %0d/%b/%0d want 14/1/28", COUNT, FULL, TSUM); end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b0, 1'b0, 0, 4);
        tick(1'b1, 1'b1, 1'b0, 5, 4);
        tick(1'b1, 1'b1, 1'b0, 6, 4);
        total++; if (COUNT !== 2 || TSUM !== 11) begin bad++; $display("FAIL mid_pre: got %0d/%0d want 2/11", COUNT, TSUM); end
        tick(1'b0, 1'b1, 1'b0, 77, 4);
        total++; if (TSUM !== 0 || TSUM_SQUARE !== 0 || COUNT !== 0 || FULL !== 1'b0)
            begin bad++; $display("FAIL mid_fill_reset: got %0d/%0d/%0d/%b want 0/0/0/0", TSUM, TSUM_SQUARE, COUNT, FULL); end
        for (int v = 1; v <= 4; v++) tick(1'b1, 1'b1, 1'b0, v + 20, 4);
        tick(1'b0, 1'b1, 1'b1, 9, 4);
        total++; if (TSUM !== 0 || TSUM_SQUARE !== 0 || COUNT !== 0 || FULL !== 1'b0)
            begin bad++; $display("FAIL mid_full_reset: got %0d/%0d/%0d/%b want 0/0/0/0", TSUM, TSUM_SQUARE, COUNT, FULL); end
        tick(1'b1, 1'b1, 1'b0, 3, 4);
        total++; if (TSUM !== 3 || TSUM_SQUARE !== 9 || COUNT !== 1 || FULL !== 1'b0)
            begin bad++; $display("FAIL mid_restart: got %0d/%0d/%0d/%b want 3/9/1/0", TSUM, TSUM_SQUARE, COUNT, FULL); end
    endtask

    task automatic test_na_one();
        int v;
        longint want;
        tick(1'b0, 1'b0, 1'b0, 0, 1);
        for (int k = 0; k < 20; k++) begin
            v = int'($urandom_range(4095));
            tick(1'b1, 1'b1, 1'b0, v, 1);
            want = longint'(v) * v;
            total++; if (TSUM !== v || TSUM_SQUARE !== want || COUNT !== 1 || FULL !== 1'b1)
                begin bad++; $display("FAIL na_one_%0d: got %0d/%0d/%0d/%b want %0d/%0d/1/1", k, TSUM, TSUM_SQUARE, COUNT, FULL, v, want); end
        end
    endtask

    task automatic test_random();
        logic rst_n, smp, clr;
        int   v;
        longint es, eq;
        tick(1'b0, 1'b0, 1'b0, 0, int'($urandom_range(15)));
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(99) != 0);
            clr   = ($urandom_range(49) == 0);
            smp   = ($urandom_range(9) < 7);
            case ($urandom_range(3))
                0:       v = 0;
                1:       v = 4095;
                default: v = int'($urandom_range(4095));
            endcase
            tick(rst_n, smp, clr, v, int'($urandom_range(15)));
            es = m_sum();
            eq = m_sq();
            total++; if (TSUM !== es) begin bad++; $display("FAIL rand_tsum@%0d: got %0d want %0d", k, TSUM, es); end
            total++; if (TSUM_SQUARE !== eq) begin bad++; $display("FAIL rand_tsq@%0d: got %0d want %0d", k, TSUM_SQUARE, eq); end
            total++; if (COUNT !== m_q.size()) begin bad++; $display("FAIL rand_count@%0d: got %0d want %0d", k, COUNT, m_q.size()); end
            total++; if (FULL !== (m_q.size() == m_na)) begin bad++; $display("FAIL rand_full@%0d: got %b want %b", k, FULL, (m_q.size() == m_na)); end
        end
    endtask

    initial begin
        RESET_N = 1'b0;
        SAMPLE  = 1'b0;
        CLEAR   = 1'b0;
        TN      = '0;
        N       = '0;
        test_reset();
        test_basic();
        test_max();
        test_hold();
        test_clear();
        test_n_limits();
        test_reset_mid();
        test_na_one();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, got running want finished");
        $fatal(1);
    end

endmodule
